// File: rtl/uart_bus_bridge.sv
// Register-mapped bridge between a simple strobe bus and a word-oriented UART controller.
// TX/RX word FIFOs plus a single sequencing FSM that drives the controller mode select.

module ubb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [31:0]                wdata,
  output logic [31:0]                head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // Callers gate push/pop against full/empty; pointers wrap since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;

  assign head = mem[rd_ptr];
endmodule

module uart_bus_bridge #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  bus_addr,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  output logic [31:0] UbUc_data_in,
  output logic        UbUc_data_in_en,
  output logic [2:0]  UnUc_wr_sel,
  input  logic [31:0] UcUb_data_out,
  input  logic        UcUb_data_out_en,
  input  logic        UcUn_txd_valid,
  input  logic        UcUn_rxd_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TX_START = 3'd1,
    TX_WAIT  = 3'd2,
    TX_CLOSE = 3'd3,
    RX_START = 3'd4,
    RX_WAIT  = 3'd5,
    RX_CLOSE = 3'd6
  } state_t;

  state_t        state;
  logic [TW-1:0] wait_cnt;
  logic          txd_prev, dout_prev;
  logic          rx_en, tx_ovf, rx_udf, timeout;

  logic [31:0]   tx_head, rx_head, rd_val, status;
  logic [AW:0]   tx_cnt, rx_cnt;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          wr_tx, rd_rx, wr_stat, wr_ctrl;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          txd_rise, dout_rise, wait_done, tx_to, rx_to;

  // The controller's rxd_ready level carries nothing the sequencing needs.
  logic unused_rxd_ready;
  assign unused_rxd_ready = UcUn_rxd_ready;

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == (AW+1)'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == (AW+1)'(FIFO_DEPTH));

  assign wr_tx   = bus_we && (bus_addr == 4'h0);
  assign rd_rx   = bus_re && (bus_addr == 4'h4);
  assign wr_stat = bus_we && (bus_addr == 4'h8);
  assign wr_ctrl = bus_we && (bus_addr == 4'hC);

  assign txd_rise  = UcUn_txd_valid & ~txd_prev;
  assign dout_rise = UcUb_data_out_en & ~dout_prev;
  assign wait_done = (wait_cnt == TW'(TIMEOUT - 1));
  assign tx_to     = (state == TX_WAIT) && !txd_rise  && wait_done;
  assign rx_to     = (state == RX_WAIT) && !dout_rise && wait_done;

  assign tx_push = wr_tx && !tx_full;
  assign tx_pop  = (state == IDLE) && !tx_empty;
  assign rx_push = (state == RX_WAIT) && dout_rise && !rx_full;
  assign rx_pop  = rd_rx && !rx_empty;

  ubb_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop),
    .wdata(bus_wdata), .head(tx_head), .count(tx_cnt));

  ubb_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop),
    .wdata(UcUb_data_out), .head(rx_head), .count(rx_cnt));

  always_comb begin
    status        = '0;
    status[0]     = tx_empty;
    status[1]     = tx_full;
    status[2]     = rx_empty;
    status[3]     = rx_full;
    status[4]     = tx_ovf;
    status[5]     = rx_udf;
    status[6]     = timeout;
    status[10:8]  = state;
    status[15:12] = 4'(tx_cnt);
    status[19:16] = 4'(rx_cnt);
  end

  always_comb begin
    rd_val = '0;
    case (bus_addr)
      4'h4:    rd_val = rx_empty ? 32'h0 : rx_head;
      4'h8:    rd_val = status;
      4'hC:    rd_val = {31'h0, rx_en};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_rdata  <= '0;
      bus_rvalid <= 1'b0;
    end else begin
      bus_rvalid <= bus_re;
      if (bus_re) bus_rdata <= rd_val;
    end
  end

  // Sticky flags: a new event in the same cycle as a W1C write wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_en     <= 1'b0;
      tx_ovf    <= 1'b0;
      rx_udf    <= 1'b0;
      timeout   <= 1'b0;
      txd_prev  <= 1'b0;
      dout_prev <= 1'b0;
    end else begin
      txd_prev  <= UcUn_txd_valid;
      dout_prev <= UcUb_data_out_en;
      if (wr_ctrl) rx_en <= bus_wdata[0];
      tx_ovf  <= (tx_ovf  & ~(wr_stat & bus_wdata[4])) | (wr_tx & tx_full);
      rx_udf  <= (rx_udf  & ~(wr_stat & bus_wdata[5])) | (rd_rx & rx_empty);
      timeout <= (timeout & ~(wr_stat & bus_wdata[6])) | tx_to | rx_to;
    end
  end

  // Outputs are set on the transition into each state so they are registered
  // and valid for the whole time the state is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      UnUc_wr_sel     <= 3'b000;
      UbUc_data_in    <= '0;
      UbUc_data_in_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!tx_empty) begin
            state           <= TX_START;
            UnUc_wr_sel     <= 3'b100;
            UbUc_data_in    <= tx_head;
            UbUc_data_in_en <= 1'b1;
          end else if (rx_en && !rx_full) begin
            state       <= RX_START;
            UnUc_wr_sel <= 3'b010;
          end
        end
        TX_START: begin
          state    <= TX_WAIT;
          wait_cnt <= '0;
        end
        TX_WAIT: begin
          if (txd_rise || tx_to) begin
            state           <= TX_CLOSE;
            UnUc_wr_sel     <= 3'b001;
            UbUc_data_in    <= '0;
            UbUc_data_in_en <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RX_START: begin
          state    <= RX_WAIT;
          wait_cnt <= '0;
        end
        RX_WAIT: begin
          if (dout_rise || rx_to) begin
            state       <= RX_CLOSE;
            UnUc_wr_sel <= 3'b001;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        TX_CLOSE, RX_CLOSE: begin
          state       <= IDLE;
          UnUc_wr_sel <= 3'b000;
        end
        default: begin
          state           <= IDLE;
          UnUc_wr_sel     <= 3'b000;
          UbUc_data_in_en <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge (FIFO_DEPTH=4, TIMEOUT=16) with hand-computed expectations.

module tb_uart_bus_bridge;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  bus_addr;
  logic        bus_we, bus_re;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_rvalid;
  logic [31:0] UbUc_data_in;
  logic        UbUc_data_in_en;
  logic [2:0]  UnUc_wr_sel;
  logic [31:0] UcUb_data_out;
  logic        UcUb_data_out_en, UcUn_txd_valid, UcUn_rxd_ready;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_bus_bridge #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_re(bus_re),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .UbUc_data_in(UbUc_data_in), .UbUc_data_in_en(UbUc_data_in_en),
    .UnUc_wr_sel(UnUc_wr_sel),
    .UcUb_data_out(UcUb_data_out), .UcUb_data_out_en(UcUb_data_out_en),
    .UcUn_txd_valid(UcUn_txd_valid), .UcUn_rxd_ready(UcUn_rxd_ready));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    step();
    bus_we = 1'b0;
  endtask

  // Read with rvalid timing, data check and hold-after check.
  task automatic bus_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
    bus_addr = a; bus_re = 1'b1;
    step();
    bus_re = 1'b0;
    chk({tag, "_rvalid"}, 32'(bus_rvalid), 32'd1);
    chk(tag, bus_rdata, exp);
    step();
    chk({tag, "_rvalid_lo"}, 32'(bus_rvalid), 32'd0);
    chk({tag, "_hold"}, bus_rdata, exp);
  endtask

  // Wait for a TX start, check the word, then complete it with a txd_valid rise in TX_WAIT.
  task automatic tx_serve(input logic [31:0] exp);
    int n = 0;
    while (UnUc_wr_sel != 3'b100 && n < 40) begin step(); n++; end
    chk("tx_sel", 32'(UnUc_wr_sel), 32'h4);
    chk("tx_data", UbUc_data_in, exp);
    chk("tx_en", 32'(UbUc_data_in_en), 32'd1);
    step();
    chk("tx_wait_sel", 32'(UnUc_wr_sel), 32'h4);
    chk("tx_wait_data", UbUc_data_in, exp);
    UcUn_txd_valid = 1'b1;
    step();
    chk("tx_close", 32'(UnUc_wr_sel), 32'h1);
    chk("tx_close_en", 32'(UbUc_data_in_en), 32'd0);
    step();
    UcUn_txd_valid = 1'b0;
    chk("tx_idle", 32'(UnUc_wr_sel), 32'h0);
  endtask

  // Entered with the FSM in RX_START; present a word with a data_out_en rise.
  task automatic rx_serve(input logic [31:0] d);
    chk("rx_start", 32'(UnUc_wr_sel), 32'h2);
    step();
    chk("rx_wait", 32'(UnUc_wr_sel), 32'h2);
    UcUb_data_out = d; UcUb_data_out_en = 1'b1;
    step();
    chk("rx_close", 32'(UnUc_wr_sel), 32'h1);
    UcUb_data_out_en = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; bus_addr = '0; bus_we = 1'b0; bus_re = 1'b0; bus_wdata = '0;
    UcUb_data_out = '0; UcUb_data_out_en = 1'b0; UcUn_txd_valid = 1'b0; UcUn_rxd_ready = 1'b0;
    step(); step();
    chk("rst_sel", 32'(UnUc_wr_sel), 32'h0);
    chk("rst_en", 32'(UbUc_data_in_en), 32'd0);
    chk("rst_din", UbUc_data_in, 32'h0);
    chk("rst_rdata", bus_rdata, 32'h0);
    chk("rst_rvalid", 32'(bus_rvalid), 32'd0);
    rst_n = 1'b1;
    step();
    bus_read("rst_status", 4'h8, 32'h0000_0005);

    // Single TX word: start one cycle after the write
    bus_write(4'h0, 32'hA5A5_1234);
    chk("tx1_not_yet", 32'(UnUc_wr_sel), 32'h0);
    step();
    chk("tx1_start", 32'(UnUc_wr_sel), 32'h4);
    tx_serve(32'hA5A5_1234);
    bus_read("tx1_status", 4'h8, 32'h0000_0005);

    // Overflow while the controller is stalled on W0
    bus_write(4'h0, 32'h1111_0000);
    step();
    chk("ovf_busy", 32'(UnUc_wr_sel), 32'h4);
    for (int i = 1; i <= 5; i++) bus_write(4'h0, 32'h1111_0000 + 32'(i));
    bus_read("ovf_status", 4'h8, 32'h0000_4216);
    bus_write(4'h8, 32'h10);
    bus_read("ovf_clr", 4'h8, 32'h0000_4206);
    for (int i = 0; i <= 4; i++) tx_serve(32'h1111_0000 + 32'(i));
    bus_read("ovf_drained", 4'h8, 32'h0000_0005);

    // RX path
    bus_write(4'hC, 32'h1);
    chk("rx_not_yet", 32'(UnUc_wr_sel), 32'h0);
    step();
    rx_serve(32'hDEAD_BEEF);
    bus_write(4'hC, 32'h0);
    chk("rx_idle", 32'(UnUc_wr_sel), 32'h0);
    step();
    chk("rx_stay_idle", 32'(UnUc_wr_sel), 32'h0);
    bus_read("rx_status1", 4'h8, 32'h0001_0001);
    bus_read("rx_data", 4'h4, 32'hDEAD_BEEF);
    bus_read("rx_status2", 4'h8, 32'h0000_0005);

    // Underflow and side-effect-free accesses
    bus_read("udf_data", 4'h4, 32'h0);
    bus_read("udf_status", 4'h8, 32'h0000_0025);
    bus_write(4'h8, 32'h20);
    bus_write(4'h4, 32'h5555_5555);
    bus_write(4'h6, 32'h7777_7777);
    bus_read("rd_txdata", 4'h0, 32'h0);
    bus_read("rd_unmapped", 4'h1, 32'h0);
    bus_read("rd_ctrl", 4'hC, 32'h0);
    bus_read("side_status", 4'h8, 32'h0000_0005);

    // TX has priority over a pending RX
    bus_write(4'h0, 32'h2222_0001);
    step();
    chk("pri_t1", 32'(UnUc_wr_sel), 32'h4);
    bus_write(4'h0, 32'h2222_0002);
    bus_write(4'hC, 32'h1);
    tx_serve(32'h2222_0001);
    tx_serve(32'h2222_0002);
    step();
    rx_serve(32'h1234_5678);
    bus_write(4'hC, 32'h0);
    bus_read("pri_rx", 4'h4, 32'h1234_5678);

    // Timeout: TX_START plus 16 TX_WAIT cycles, then one close cycle
    bus_write(4'h0, 32'hCAFE_0001);
    n = 0;
    while (UnUc_wr_sel != 3'b100 && n < 10) begin step(); n++; end
    n = 0;
    while (UnUc_wr_sel == 3'b100 && n < 100) begin n++; step(); end
    chk("to_cycles", 32'(n), 32'd17);
    chk("to_close", 32'(UnUc_wr_sel), 32'h1);
    chk("to_close_en", 32'(UbUc_data_in_en), 32'd0);
    step();
    chk("to_idle", 32'(UnUc_wr_sel), 32'h0);
    bus_read("to_status", 4'h8, 32'h0000_0045);
    bus_write(4'h8, 32'h40);

    // Reset in the middle of a wait
    bus_write(4'h0, 32'hBEEF_0002);
    step(); step(); step();
    chk("mid_sel", 32'(UnUc_wr_sel), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", 32'(UnUc_wr_sel), 32'h0);
    chk("mid_rst_en", 32'(UbUc_data_in_en), 32'd0);
    chk("mid_rst_din", UbUc_data_in, 32'h0);
    chk("mid_rst_rdata", bus_rdata, 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_rst_sel", 32'(UnUc_wr_sel), 32'h0);
    step();
    chk("post_rst_sel2", 32'(UnUc_wr_sel), 32'h0);
    bus_read("post_rst_status", 4'h8, 32'h0000_0005);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
